// File: rtl/uart_mem_dump.sv
// Streams a range of 32-bit RAM words out as UART 8N1 bytes, little-endian.
// Optional checksum trailer byte is enabled by defining DUMP_CHKSUM_EN.
module uart_mem_dump #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              dump_start_i,
  input  logic [ADDR_W-1:0] dump_base_i,
  input  logic [ADDR_W:0]   dump_len_i,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  input  logic [31:0]       mem_dat_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_adr;
  logic [ADDR_W:0]   r_remain;
  logic [31:0]       r_word;
  logic [7:0]        w_byte;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

`ifdef DUMP_CHKSUM_EN
  logic       r_trailer;
  logic [7:0] r_sum;
  assign w_byte = r_trailer ? r_sum : r_word[{r_byte_idx, 3'b000} +: 8];
`else
  assign w_byte = r_word[{r_byte_idx, 3'b000} +: 8];
`endif

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dump_start_i) begin
          if (dump_len_i != '0) w_state_next = S_READ;
`ifdef DUMP_CHKSUM_EN
          else                  w_state_next = S_START;
`else
          else                  w_state_next = S_DONE;
`endif
        end
      end
      S_READ:  w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_START;
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_next = S_STOP;
      S_STOP: begin
        if (w_bit_end) begin
`ifdef DUMP_CHKSUM_EN
          if (r_trailer)               w_state_next = S_DONE;
          else if (r_byte_idx != 2'd3) w_state_next = S_START;
          else if (r_remain != '0)     w_state_next = S_READ;
          else                         w_state_next = S_START;
`else
          if (r_byte_idx != 2'd3)      w_state_next = S_START;
          else if (r_remain != '0)     w_state_next = S_READ;
          else                         w_state_next = S_DONE;
`endif
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      r_cur      <= '0;
      r_adr      <= '0;
      r_remain   <= '0;
      r_word     <= '0;
`ifdef DUMP_CHKSUM_EN
      r_trailer  <= 1'b0;
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_start_i) begin
            r_cur    <= dump_base_i;
            r_remain <= dump_len_i;
`ifdef DUMP_CHKSUM_EN
            r_sum     <= '0;
            r_trailer <= (dump_len_i == '0);
`endif
          end
        end
        S_READ: begin
          r_adr    <= r_cur;
          r_cur    <= r_cur + 1'b1;
          r_remain <= r_remain - 1'b1;
        end
        // RAM data is only guaranteed valid the cycle after the read strobe.
        S_WAIT: r_word <= mem_dat_i;
        S_LOAD: begin
          r_byte_idx <= '0;
          r_bit      <= '0;
          r_baud     <= '0;
        end
        S_START, S_DATA, S_STOP: begin
          r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
          if (w_bit_end && r_state == S_DATA) r_bit <= r_bit + 1'b1;
          if (w_bit_end && r_state == S_STOP) begin
            r_byte_idx <= r_byte_idx + 1'b1;
`ifdef DUMP_CHKSUM_EN
            if (!r_trailer) begin
              r_sum <= r_sum + w_byte;
              if (r_byte_idx == 2'd3 && r_remain == '0) r_trailer <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ren_o = (r_state == S_READ);
  assign mem_adr_o = (r_state == S_READ) ? r_cur : r_adr;
  assign busy_o    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o    = (r_state == S_DONE);

  always_comb begin
    tx_o = 1'b1;
    if (r_state == S_START)     tx_o = 1'b0;
    else if (r_state == S_DATA) tx_o = w_byte[r_bit];
  end

endmodule
